writeback_arbiter: RTL

Merges result streams from the single-cycle ALU and the variable-latency load unit onto the single register-file write port (we3/wa3/wd3). Each source has a valid/ready handshake and a one-entry holding buffer. The arbiter grants one buffered result per cycle and registers it onto the write port. It also exposes pending-write hit flags so the decode stage can stall on read-after-write hazards.

---
 rtl/writeback_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges ALU and load results onto the register-file write port.
// Define WB_RR_ARB_EN for round-robin arbitration; the default is fixed mem-over-alu priority.
module writeback_arbiter #(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [XLEN-1:0]   wd3,
  input  logic [ADDR_W-1:0] chk_ra1,
  input  logic [ADDR_W-1:0] chk_ra2,
  output logic              chk_hit1,
  output logic              chk_hit2,
  output logic              busy
);

  logic              alu_full, mem_full;
  logic [ADDR_W-1:0] alu_buf_rd, mem_buf_rd;
  logic [XLEN-1:0]   alu_buf_data, mem_buf_data;

  logic alu_elig, mem_elig;
  logic grant_alu, grant_mem;
  logic alu_drain, mem_drain;

  assign alu_elig = alu_full && (alu_buf_rd != '0);
  assign mem_elig = mem_full && (mem_buf_rd != '0);

`ifdef WB_RR_ARB_EN
  // last_alu = 1 means the alu was granted last, so mem wins the next tie
  logic last_alu;

  always_comb begin
    grant_mem = mem_elig && (!alu_elig || last_alu);
    grant_alu = alu_elig && (!mem_elig || !last_alu);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_alu <= 1'b1;
    end else if (grant_alu) begin
      last_alu <= 1'b1;
    end else if (grant_mem) begin
      last_alu <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_mem = mem_elig;
    grant_alu = alu_elig && !mem_elig;
  end
`endif

  // x0 entries leave the buffer without taking a write slot
  assign alu_drain = grant_alu || (alu_full && (alu_buf_rd == '0));
  assign mem_drain = grant_mem || (mem_full && (mem_buf_rd == '0));

  assign alu_ready = !alu_full || alu_drain;
  assign mem_ready = !mem_full || mem_drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_full     <= 1'b0;
      alu_buf_rd   <= '0;
      alu_buf_data <= '0;
    end else if (alu_valid && alu_ready) begin
      alu_full     <= 1'b1;
      alu_buf_rd   <= alu_rd;
      alu_buf_data <= alu_data;
    end else if (alu_drain) begin
      alu_full     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_full     <= 1'b0;
      mem_buf_rd   <= '0;
      mem_buf_data <= '0;
    end else if (mem_valid && mem_ready) begin
      mem_full     <= 1'b1;
      mem_buf_rd   <= mem_rd;
      mem_buf_data <= mem_data;
    end else if (mem_drain) begin
      mem_full     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (grant_mem) begin
      we3 <= 1'b1;
      wa3 <= mem_buf_rd;
      wd3 <= mem_buf_data;
    end else if (grant_alu) begin
      we3 <= 1'b1;
      wa3 <= alu_buf_rd;
      wd3 <= alu_buf_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  assign chk_hit1 = (chk_ra1 != '0) &&
                    ((alu_full && (alu_buf_rd == chk_ra1)) ||
                     (mem_full && (mem_buf_rd == chk_ra1)) ||
                     (we3 && (wa3 == chk_ra1)));
  assign chk_hit2 = (chk_ra2 != '0) &&
                    ((alu_full && (alu_buf_rd == chk_ra2)) ||
                     (mem_full && (mem_buf_rd == chk_ra2)) ||
                     (we3 && (wa3 == chk_ra2)));

  assign busy = alu_full || mem_full || we3;

endmodule
